// File: rtl/execution_stage_muldiv.sv
// Execution stage: single-cycle ALU/branch unit plus an iterative RV32M/RV64M
// multiply/divide unit. All results are registered into the EX/MEM boundary.
// MULDIV_BUSY tells the hazard unit to hold the ID/EX inputs.
module execution_stage_muldiv #(
   parameter int XLEN          = 32,
   parameter bit MULDIV_ENABLE = 1'b1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            STALL_EXECUTION_STAGE,
   input  logic            CLEAR_EXECUTION_STAGE,
   input  logic [XLEN-1:0] PC_IN,
   input  logic [4:0]      RD_ADDRESS_IN,
   input  logic [XLEN-1:0] RS1_DATA,
   input  logic [XLEN-1:0] RS2_DATA,
   input  logic [XLEN-1:0] IMM_DATA,
   input  logic [4:0]      ALU_INSTRUCTION,
   input  logic            ALU_INPUT_1_SELECT,
   input  logic            ALU_INPUT_2_SELECT,
   input  logic [2:0]      DATA_CACHE_LOAD_IN,
   input  logic [1:0]      DATA_CACHE_STORE_IN,
   input  logic            WRITE_BACK_MUX_SELECT_IN,
   input  logic            RD_WRITE_ENABLE_IN,
   output logic [4:0]      RD_ADDRESS_OUT,
   output logic [XLEN-1:0] ALU_OUT,
   output logic            BRANCH_TAKEN,
   output logic [2:0]      DATA_CACHE_LOAD_OUT,
   output logic [1:0]      DATA_CACHE_STORE_OUT,
   output logic            WRITE_BACK_MUX_SELECT_OUT,
   output logic            RD_WRITE_ENABLE_OUT,
   output logic [XLEN-1:0] DATA_CACHE_STORE_DATA,
   output logic            MULDIV_BUSY
);
   localparam int SHW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   // Everything the stage hands to EX/MEM; a bubble is this struct all zero.
   typedef struct packed {
      logic [4:0]      rd_address;
      logic [XLEN-1:0] alu;
      logic            branch_taken;
      logic [2:0]      load;
      logic [1:0]      store;
      logic            wb_select;
      logic            rd_write_enable;
      logic [XLEN-1:0] store_data;
   } stage_t;

   state_t            state, next_state;
   logic [SHW-1:0]    count;
   stage_t            stage_q, stage_d, held_ctrl;
   logic [2:0]        m_op;
   logic              a_neg, b_neg, div_zero;
   logic [2*XLEN-1:0] acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
   logic [XLEN-1:0]   opb;      // mul: multiplicand magnitude; div: divisor magnitude

   logic [XLEN-1:0]   op1, op2, alu_result, mag_a, mag_b, muldiv_result;
   logic [SHW-1:0]    shamt;
   logic              branch_result, is_m_op, a_signed, b_signed, a_neg_in, b_neg_in;
   logic [2:0]        m_op_in;
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0] acc_step, prod_fixed;
   logic [XLEN-1:0]   quo_fixed, rem_fixed;

   assign op1     = ALU_INPUT_1_SELECT ? PC_IN : RS1_DATA;
   assign op2     = ALU_INPUT_2_SELECT ? IMM_DATA : RS2_DATA;
   assign shamt   = op2[SHW-1:0];
   assign is_m_op = MULDIV_ENABLE && (ALU_INSTRUCTION[4:3] == 2'b10);

   // Operand signedness by funct3: MUL/MULH/MULHSU/DIV/REM treat rs1 as signed,
   // MUL/MULH/DIV/REM treat rs2 as signed. The engine works on magnitudes.
   assign m_op_in  = ALU_INSTRUCTION[2:0];
   assign a_signed = m_op_in[2] ? ~m_op_in[0] : (m_op_in != 3'd3);
   assign b_signed = m_op_in[2] ? ~m_op_in[0] : ~m_op_in[1];
   assign a_neg_in = a_signed & op1[XLEN-1];
   assign b_neg_in = b_signed & op2[XLEN-1];
   assign mag_a    = a_neg_in ? -op1 : op1;
   assign mag_b    = b_neg_in ? -op2 : op2;

   // Single-cycle ALU; branch ops produce the target address op1+op2.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      alu_result = '0;
      case (ALU_INSTRUCTION)
         5'd0:  alu_result = op1 + op2;
         5'd1:  alu_result = op1 - op2;
         5'd2:  alu_result = op1 << shamt;
         5'd3:  alu_result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
         5'd4:  alu_result = {{(XLEN-1){1'b0}}, (op1 < op2)};
         5'd5:  alu_result = op1 ^ op2;
         5'd6:  alu_result = op1 >> shamt;
         5'd7:  alu_result = $signed(op1) >>> shamt;
         5'd8:  alu_result = op1 | op2;
         5'd9:  alu_result = op1 & op2;
         5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15: alu_result = op1 + op2;
         default: alu_result = '0;
      endcase
   end

   // Branch condition always compares the raw register operands.
   always_comb begin
      branch_result = 1'b0;
      case (ALU_INSTRUCTION)
         5'd10: branch_result = (RS1_DATA == RS2_DATA);
         5'd11: branch_result = (RS1_DATA != RS2_DATA);
         5'd12: branch_result = ($signed(RS1_DATA) <  $signed(RS2_DATA));
         5'd13: branch_result = ($signed(RS1_DATA) >= $signed(RS2_DATA));
         5'd14: branch_result = (RS1_DATA <  RS2_DATA);
         5'd15: branch_result = (RS1_DATA >= RS2_DATA);
         default: branch_result = 1'b0;
      endcase
   end

   // One shift-add (multiply) or restoring-subtract (divide) iteration.
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
      div_shift = acc[2*XLEN-1:XLEN-1];
      div_diff  = div_shift - {1'b0, opb};
      if (m_op[2])
         acc_step = {(div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                     acc[XLEN-2:0], ~div_diff[XLEN]};
      else
         acc_step = {mul_sum, acc[XLEN-1:1]};
   end

   // Sign fix-up and result select applied on the FIN edge.
   always_comb begin
      prod_fixed = (a_neg ^ b_neg) ? -acc : acc;
      quo_fixed  = div_zero ? '1 : ((a_neg ^ b_neg) ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
      rem_fixed  = a_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (m_op)
         3'd0:             muldiv_result = prod_fixed[XLEN-1:0];
         3'd1, 3'd2, 3'd3: muldiv_result = prod_fixed[2*XLEN-1:XLEN];
         3'd4, 3'd5:       muldiv_result = quo_fixed;
         default:          muldiv_result = rem_fixed;
      endcase
   end

   // FSM next state and the value the stage register loads on a normal edge.
   always_comb begin
      next_state = state;
      stage_d    = '0;
      case (state)
         IDLE: begin
            if (is_m_op) begin
               next_state = CALC;
            end else begin
               stage_d.rd_address      = RD_ADDRESS_IN;
               stage_d.alu             = alu_result;
               stage_d.branch_taken    = branch_result;
               stage_d.load            = DATA_CACHE_LOAD_IN;
               stage_d.store           = DATA_CACHE_STORE_IN;
               stage_d.wb_select       = WRITE_BACK_MUX_SELECT_IN;
               stage_d.rd_write_enable = RD_WRITE_ENABLE_IN;
               stage_d.store_data      = RS2_DATA;
            end
         end
         CALC: if (count == SHW'(XLEN-1)) next_state = FIN;
         FIN: begin
            next_state  = IDLE;
            stage_d     = held_ctrl;
            stage_d.alu = muldiv_result;
         end
         default: next_state = IDLE;
      endcase
   end

   // FSM state register: clear beats stall.
   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (RST)                        state <= IDLE;
      else if (CLEAR_EXECUTION_STAGE) state <= IDLE;
      else if (!STALL_EXECUTION_STAGE) state <= next_state;
   end

   // EX/MEM output register: clear loads a bubble, stall holds.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                         stage_q <= '0;
      else if (CLEAR_EXECUTION_STAGE)  stage_q <= '0;
      else if (!STALL_EXECUTION_STAGE) stage_q <= stage_d;
   end

   // Multiply/divide operand capture, iteration and counter.
   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: datapath registers are reset too, so an aborted op leaves no stale operands behind.
      if (RST) begin
         count     <= '0;
         acc       <= '0;
         opb       <= '0;
         m_op      <= '0;
         a_neg     <= 1'b0;
         b_neg     <= 1'b0;
         div_zero  <= 1'b0;
         held_ctrl <= '0;
      end else if (CLEAR_EXECUTION_STAGE) begin
         count <= '0;
      end else if (!STALL_EXECUTION_STAGE) begin
         case (state)
            IDLE: if (is_m_op) begin
               count     <= '0;
               m_op      <= m_op_in;
               a_neg     <= a_neg_in;
               b_neg     <= b_neg_in;
               div_zero  <= (op2 == '0);
               acc       <= {{XLEN{1'b0}}, (m_op_in[2] ? mag_a : mag_b)};
               opb       <= m_op_in[2] ? mag_b : mag_a;
               held_ctrl <= '{rd_address: RD_ADDRESS_IN, alu: '0, branch_taken: 1'b0,
                              load: DATA_CACHE_LOAD_IN, store: DATA_CACHE_STORE_IN,
                              wb_select: WRITE_BACK_MUX_SELECT_IN,
                              rd_write_enable: RD_WRITE_ENABLE_IN, store_data: RS2_DATA};
            end
            CALC: begin
               acc   <= acc_step;
               count <= count + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign RD_ADDRESS_OUT            = stage_q.rd_address;
   assign ALU_OUT                   = stage_q.alu;
   assign BRANCH_TAKEN              = stage_q.branch_taken;
   assign DATA_CACHE_LOAD_OUT       = stage_q.load;
   assign DATA_CACHE_STORE_OUT      = stage_q.store;
   assign WRITE_BACK_MUX_SELECT_OUT = stage_q.wb_select;
   assign RD_WRITE_ENABLE_OUT       = stage_q.rd_write_enable;
   assign DATA_CACHE_STORE_DATA     = stage_q.store_data;
   assign MULDIV_BUSY               = (state != IDLE);
endmodule

// File: tb/tb_execution_stage_muldiv.sv
// Self-checking bench for execution_stage_muldiv (XLEN=32): a reference model
// pushes expected stage outputs into a scoreboard queue at issue time; they are
// popped and compared when the stage presents its result.
module tb_execution_stage_muldiv;
   localparam int XLEN = 32;

   logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, clear = 1'b0;
   logic [31:0] pc_in = '0, rs1 = '0, rs2 = '0, imm = '0;
   logic [4:0]  rd_in = '0, alu_instr = '0;
   logic        sel1 = 1'b0, sel2 = 1'b0, wb_in = 1'b0, we_in = 1'b0;
   logic [2:0]  dcl_in = '0;
   logic [1:0]  dcs_in = '0;
   logic [4:0]  rd_out;
   logic [31:0] alu_out, sd_out;
   logic        br_out, wb_out, we_out, busy;
   logic [2:0]  dcl_out;
   logic [1:0]  dcs_out;

   typedef struct {
      logic [31:0] alu;
      logic        br;
      logic [4:0]  rd;
      logic        we;
      logic [2:0]  dcl;
      logic [1:0]  dcs;
      logic        wb;
      logic [31:0] sd;
   } exp_t;

   exp_t        exp_q[$];
   int          n_tests = 0, n_fail = 0;
   logic [31:0] last_alu = '0;

   execution_stage_muldiv #(.XLEN(XLEN), .MULDIV_ENABLE(1'b1)) dut (
      .CLK(clk), .RST(rst),
      .STALL_EXECUTION_STAGE(stall), .CLEAR_EXECUTION_STAGE(clear),
      .PC_IN(pc_in), .RD_ADDRESS_IN(rd_in), .RS1_DATA(rs1), .RS2_DATA(rs2), .IMM_DATA(imm),
      .ALU_INSTRUCTION(alu_instr), .ALU_INPUT_1_SELECT(sel1), .ALU_INPUT_2_SELECT(sel2),
      .DATA_CACHE_LOAD_IN(dcl_in), .DATA_CACHE_STORE_IN(dcs_in),
      .WRITE_BACK_MUX_SELECT_IN(wb_in), .RD_WRITE_ENABLE_IN(we_in),
      .RD_ADDRESS_OUT(rd_out), .ALU_OUT(alu_out), .BRANCH_TAKEN(br_out),
      .DATA_CACHE_LOAD_OUT(dcl_out), .DATA_CACHE_STORE_OUT(dcs_out),
      .WRITE_BACK_MUX_SELECT_OUT(wb_out), .RD_WRITE_ENABLE_OUT(we_out),
      .DATA_CACHE_STORE_DATA(sd_out), .MULDIV_BUSY(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   // Reference ALU / M-extension model built on the simulator's wide arithmetic.
   function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         5'd0:  return a + b;
         5'd1:  return a - b;
         5'd2:  return a << b[4:0];
         5'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         5'd4:  return (a < b) ? 32'd1 : 32'd0;
         5'd5:  return a ^ b;
         5'd6:  return a >> b[4:0];
         5'd7:  return $signed(a) >>> b[4:0];
         5'd8:  return a | b;
         5'd9:  return a & b;
         5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15: return a + b;
         5'd16: begin p = sa * sb; return p[31:0];  end
         5'd17: begin p = sa * sb; return p[63:32]; end
         5'd18: begin p = sa * ub; return p[63:32]; end
         5'd19: begin p = ua * ub; return p[63:32]; end
         5'd20: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return $signed(a) / $signed(b);
         end
         5'd21: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         5'd22: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return $signed(a) % $signed(b);
         end
         5'd23: return (b == 32'd0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic br_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         5'd10: return a == b;
         5'd11: return a != b;
         5'd12: return $signed(a) <  $signed(b);
         5'd13: return $signed(a) >= $signed(b);
         5'd14: return a <  b;
         5'd15: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic drive(input logic [4:0] op, input logic [31:0] a, b, p, i,
                        input logic s1, s2, input logic [4:0] rd);
      alu_instr = op; rs1 = a; rs2 = b; pc_in = p; imm = i;
      sel1 = s1; sel2 = s2; rd_in = rd; we_in = 1'b1;
      dcl_in = 3'($urandom); dcs_in = 2'($urandom); wb_in = 1'($urandom);
   endtask

   // Issue one instruction at a negedge, wait for its result, compare against the scoreboard.
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a, b, p, i,
                         input logic s1, s2, input logic [4:0] rd, input int stall_at, stall_len);
      exp_t e;
      int   busy_cycles, bad;
      drive(op, a, b, p, i, s1, s2, rd);
      e.alu = alu_model(op, s1 ? p : a, s2 ? i : b);
      e.br  = br_model(op, a, b);
      e.rd  = rd;  e.we = 1'b1; e.dcl = dcl_in; e.dcs = dcs_in; e.wb = wb_in; e.sd = b;
      exp_q.push_back(e);
      @(posedge clk); @(negedge clk);
      if (op[4:3] == 2'b10) begin
         check({tag, "_busy"}, 64'(busy), 64'd1);
         // Garbage on the inputs while busy must be ignored.
         drive(5'd0, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0, 5'd31);
         busy_cycles = 0;
         bad = 0;
         while (busy && busy_cycles < 200) begin
            if (alu_out != 32'd0 || we_out || rd_out != 5'd0) bad++;
            busy_cycles++;
            stall = (busy_cycles >= stall_at) && (busy_cycles < stall_at + stall_len);
            @(negedge clk);
         end
         stall = 1'b0;
         check({tag, "_latency"}, 64'(busy_cycles), 64'(XLEN + 1 + stall_len));
         check({tag, "_bubble"}, 64'(bad), 64'd0);
      end
      e = exp_q.pop_front();
      check({tag, "_alu"},  64'(alu_out), 64'(e.alu));
      check({tag, "_br"},   64'(br_out),  64'(e.br));
      check({tag, "_rd"},   64'(rd_out),  64'(e.rd));
      check({tag, "_we"},   64'(we_out),  64'(e.we));
      check({tag, "_ctl"},  64'({dcl_out, dcs_out, wb_out}), 64'({e.dcl, e.dcs, e.wb}));
      check({tag, "_sd"},   64'(sd_out),  64'(e.sd));
      check({tag, "_idle"}, 64'(busy),    64'd0);
      last_alu = e.alu;
   endtask

   initial begin
      int spurious;
      repeat (2) @(negedge clk);
      check("rst_alu",  64'(alu_out), 64'd0);
      check("rst_ctl",  64'({rd_out, br_out, dcl_out, dcs_out, wb_out, we_out}), 64'd0);
      check("rst_sd",   64'(sd_out), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;

      run_op("add",     5'd0,  32'd2, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd5, 0, 0);
      run_op("mul",     5'd16, 32'd7, 32'hFFFF_FFFD, 32'd0, 32'd0, 1'b0, 1'b0, 5'd6, 0, 0);
      run_op("mulh",    5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 5'd7, 0, 0);
      run_op("mulhu",   5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 5'd8, 0, 0);
      run_op("mulhsu",  5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 5'd8, 0, 0);
      run_op("div",     5'd20, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 5'd9, 0, 0);
      run_op("rem",     5'd22, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 5'd10, 0, 0);
      run_op("divu_z",  5'd21, 32'd9, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd11, 0, 0);
      run_op("div_z",   5'd20, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd11, 0, 0);
      run_op("rem_z",   5'd22, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd12, 0, 0);
      run_op("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 5'd13, 0, 0);
      run_op("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 5'd14, 0, 0);
      run_op("divu_st", 5'd21, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 5'd15, 10, 5);

      // Stall on a single-cycle op holds the outputs.
      run_op("add_s",   5'd0, 32'd10, 32'd20, 32'd0, 32'd0, 1'b0, 1'b0, 5'd16, 0, 0);
      stall = 1'b1;
      drive(5'd1, 32'd100, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd17);
      repeat (3) @(negedge clk);
      check("stall_alu", 64'(alu_out), 64'(last_alu));
      check("stall_rd",  64'(rd_out),  64'd16);
      stall = 1'b0;
      run_op("sub",     5'd1, 32'd100, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd17, 0, 0);

      // Clear on a single-cycle op and in the middle of a divide.
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_alu", 64'(alu_out), 64'd0);
      check("clr_ctl", 64'({rd_out, dcl_out, dcs_out, wb_out, we_out}), 64'd0);
      drive(5'd20, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 5'd18);
      @(posedge clk); @(negedge clk);
      repeat (9) @(negedge clk);
      check("clr_busy_before", 64'(busy), 64'd1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_mid_busy", 64'(busy), 64'd0);
      check("clr_mid_out",  64'({alu_out, rd_out, we_out}), 64'd0);
      run_op("add_clr", 5'd0, 32'd4, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 5'd19, 0, 0);

      // Asynchronous reset: outputs drop between clock edges.
      #2 rst = 1'b1;
      #1 check("arst_alu", 64'(alu_out), 64'd0);
      check("arst_we", 64'(we_out), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(5'd21, 32'd12345, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 5'd20);
      @(posedge clk); @(negedge clk);
      repeat (5) @(negedge clk);
      check("arst_div_busy_before", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1 check("arst_div_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      alu_instr = 5'd0; we_in = 1'b0; rd_in = 5'd0;
      spurious = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (we_out || busy) spurious++;
      end
      check("arst_abort", 64'(spurious), 64'd0);

      // Branches.
      run_op("blt",  5'd12, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 0, 0);
      run_op("bltu", 5'd14, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 0, 0);
      run_op("beq",  5'd10, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1'b1, 5'd0, 0, 0);

      // Random single-cycle, M-extension and illegal ops.
      for (int k = 0; k < 10; k++)
         run_op("rnd_alu", 5'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom,
                1'($urandom), 1'($urandom), 5'($urandom), 0, 0);
      for (int k = 0; k < 10; k++)
         run_op("rnd_m", 5'($urandom_range(16, 23)), $urandom,
                (k % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom,
                32'd0, 32'd0, 1'b0, 1'b0, 5'($urandom), 0, 0);
      for (int k = 0; k < 3; k++)
         run_op("illegal", 5'($urandom_range(24, 31)), $urandom, $urandom, $urandom, $urandom,
                1'b0, 1'b0, 5'($urandom), 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
